// File: rtl/flight_mode_if.sv
// flight_mode_if: bundles the command handshake, warp/abort/overflow inputs
// and the mux-select outputs of one flight_mode_controller axis.
//   cmd_valid/cmd_mode/cmd_ready : mode command handshake
//   warp_req, abort, pos_overflow: sequencing inputs
//   mode_sel, pos_sel            : one-hot mux selects
//   warp_active, cooldown, fault : status outputs
// master = the command source / datapath, slave = the controller.
interface flight_mode_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       warp_req;
  logic       abort;
  logic       pos_overflow;
  logic [3:0] mode_sel;
  logic [3:0] pos_sel;
  logic       warp_active;
  logic       cooldown;
  logic       fault;

  modport master (
    output cmd_valid, cmd_mode, warp_req, abort, pos_overflow,
    input  cmd_ready, mode_sel, pos_sel, warp_active, cooldown, fault
  );

  modport slave (
    input  cmd_valid, cmd_mode, warp_req, abort, pos_overflow,
    output cmd_ready, mode_sel, pos_sel, warp_active, cooldown, fault
  );
endinterface

// File: rtl/flight_mode_controller.sv
// flight_mode_controller: per-axis sequencer for the position datapath.
// Drives the one-hot velocity/mode mux and position mux selects, runs the
// warp sequence CHARGE -> JUMP -> COOL, and parks in FAULT when the position
// adder overflows.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - flight_mode_if.slave (command handshake, warp_req, abort,
//          pos_overflow in; mode_sel, pos_sel, warp_active, cooldown,
//          fault, cmd_ready out)
module flight_mode_controller #(
  parameter int WARP_CHARGE_CYCLES   = 8,
  parameter int WARP_COOLDOWN_CYCLES = 16,
  parameter int CNT_W                = 5
) (
  input logic          clk,
  input logic          rst,
  flight_mode_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRUISE = 3'd1,
    ST_CHARGE = 3'd2,
    ST_JUMP   = 3'd3,
    ST_COOL   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] mode_sel;
    logic [3:0] pos_sel;
    logic       warp_active;
    logic       cooldown;
    logic       fault;
  } outs_t;

  localparam logic [CNT_W-1:0] CHARGE_LOAD = CNT_W'(WARP_CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(WARP_COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       saved_mode;
  outs_t            outs;
  logic             cmd_fire;
  logic             warp_live;

  function automatic logic [3:0] mode_onehot(input logic [1:0] m);
    case (m)
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      2'b11:   return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  // Output pattern for the state being entered; every transition below loads
  // the registered outputs from this so they change on the same edge as state.
  function automatic outs_t decode(input state_t s, input logic [1:0] m);
    outs_t o;
    o = '{mode_sel: 4'b0001, pos_sel: 4'b0001, warp_active: 1'b0,
          cooldown: 1'b0, fault: 1'b0};
    case (s)
      ST_CRUISE: begin
        o.pos_sel  = 4'b0010;
        o.mode_sel = mode_onehot(m);
      end
      ST_CHARGE: begin
        o.pos_sel  = 4'b0010;
        o.mode_sel = 4'b1000;
      end
      ST_JUMP: begin
        o.pos_sel     = 4'b0100;
        o.mode_sel    = 4'b1000;
        o.warp_active = 1'b1;
      end
      ST_COOL: begin
        o.pos_sel  = 4'b0010;
        o.mode_sel = 4'b0100;
        o.cooldown = 1'b1;
      end
      ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // cmd_ready is a pure decode of state so the source sees it in the same
  // cycle; commands are only ever taken in IDLE, CRUISE and FAULT.
  assign bus.cmd_ready = (state == ST_IDLE) || (state == ST_CRUISE) ||
                         (state == ST_FAULT);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  // Overflow only matters while the adder is feeding the position.
  assign warp_live     = (state == ST_CRUISE) || (state == ST_CHARGE) ||
                         (state == ST_JUMP)   || (state == ST_COOL);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of state, cnt and saved_mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      saved_mode <= 2'b00;
      outs       <= decode(ST_IDLE, 2'b00);
    end else if (bus.abort) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      saved_mode <= 2'b00;
      outs       <= decode(ST_IDLE, 2'b00);
    end else if (bus.pos_overflow && warp_live) begin
      state <= ST_FAULT;
      cnt   <= '0;
      outs  <= decode(ST_FAULT, saved_mode);
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire && (bus.cmd_mode != 2'b00)) begin
            saved_mode <= bus.cmd_mode;
            state      <= ST_CRUISE;
            outs       <= decode(ST_CRUISE, bus.cmd_mode);
          end
        end
        ST_CRUISE: begin
          // A same-cycle command is still handshaken but dropped here.
          if (bus.warp_req) begin
            state <= ST_CHARGE;
            cnt   <= CHARGE_LOAD;
            outs  <= decode(ST_CHARGE, saved_mode);
          end else if (cmd_fire) begin
            if (bus.cmd_mode == 2'b00) begin
              state <= ST_IDLE;
              outs  <= decode(ST_IDLE, 2'b00);
            end else begin
              saved_mode <= bus.cmd_mode;
              outs       <= decode(ST_CRUISE, bus.cmd_mode);
            end
          end
        end
        ST_CHARGE: begin
          if (cnt == '0) begin
            state <= ST_JUMP;
            outs  <= decode(ST_JUMP, saved_mode);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_JUMP: begin
          state <= ST_COOL;
          cnt   <= COOL_LOAD;
          outs  <= decode(ST_COOL, saved_mode);
        end
        ST_COOL: begin
          if (cnt == '0) begin
            state <= ST_CRUISE;
            outs  <= decode(ST_CRUISE, saved_mode);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_FAULT: begin
          // Non-zero commands are accepted and discarded; only park clears.
          if (cmd_fire && (bus.cmd_mode == 2'b00)) begin
            state <= ST_IDLE;
            outs  <= decode(ST_IDLE, 2'b00);
          end
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          saved_mode <= 2'b00;
          outs       <= decode(ST_IDLE, 2'b00);
        end
      endcase
    end
  end

  assign bus.mode_sel    = outs.mode_sel;
  assign bus.pos_sel     = outs.pos_sel;
  assign bus.warp_active = outs.warp_active;
  assign bus.cooldown    = outs.cooldown;
  assign bus.fault       = outs.fault;

endmodule
